// File: rtl/fft_twd_pkg.sv
// Twiddle kinds, twiddle word layout and per-stage twiddle tables for the
// inter-stage twiddle multiplier.
package fft_twd_pkg;

    localparam int TWD_FRAC  = 8;
    localparam int TWD_N_IDX = 4;
    localparam int W8_1      = 181;

    typedef enum logic [1:0] {
        TW_ONE = 2'd0,
        TW_MJ  = 2'd1,
        TW_GEN = 2'd2
    } twd_kind_e;

    typedef struct packed {
        twd_kind_e                  kind;
        logic signed [TWD_FRAC+1:0] re;
        logic signed [TWD_FRAC+1:0] im;
    } twd_t;

    localparam logic signed [TWD_FRAC+1:0] C_ZERO = '0;
    localparam logic signed [TWD_FRAC+1:0] C_ONE  = (TWD_FRAC+2)'(1 << TWD_FRAC);
    localparam logic signed [TWD_FRAC+1:0] C_W8   = (TWD_FRAC+2)'(W8_1);

    // Forward-FFT convention: W8^k = exp(-j*pi*k/4)
    localparam twd_t T_ONE = '{TW_ONE, C_ONE, C_ZERO};
    localparam twd_t T_MJ  = '{TW_MJ, C_ZERO, -C_ONE};
    localparam twd_t T_W81 = '{TW_GEN, C_W8, -C_W8};
    localparam twd_t T_W83 = '{TW_GEN, -C_W8, -C_W8};

    localparam twd_t TWD_TAB [3][TWD_N_IDX] = '{
        '{T_ONE, T_ONE, T_ONE, T_ONE},
        '{T_ONE, T_ONE, T_MJ,  T_W81},
        '{T_ONE, T_MJ,  T_W81, T_W83}
    };

endpackage

// File: rtl/cmul_rnd_sat.sv
// One lane of the diff-branch twiddle multiply: stage 1 forms the four partial
// products, stage 2 selects by twiddle kind, rounds half-up and saturates.
module cmul_rnd_sat
    import fft_twd_pkg::*;
#(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 13,
    parameter int TW_FRAC = TWD_FRAC
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en_s1,
    input  logic                      en_s2,
    input  twd_kind_e                 kind,
    input  logic signed [TW_FRAC+1:0] tw_re,
    input  logic signed [TW_FRAC+1:0] tw_im,
    input  logic signed [IN_W-1:0]    a,
    input  logic signed [IN_W-1:0]    b,
    output logic signed [OUT_W-1:0]   o_re,
    output logic signed [OUT_W-1:0]   o_im,
    output logic                      sat
);

    localparam int PW = IN_W + TW_FRAC + 2;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] MAXV = SW'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);
    localparam logic signed [SW-1:0] RND  = SW'(longint'(1) << (TW_FRAC - 1));

    twd_kind_e              kind_s1;
    logic signed [IN_W-1:0] a_s1, b_s1;
    logic signed [PW-1:0]   ac, bd, ad, bc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kind_s1 <= TW_ONE;
            a_s1    <= '0;
            b_s1    <= '0;
            ac      <= '0;
            bd      <= '0;
            ad      <= '0;
            bc      <= '0;
        end else if (en_s1) begin
            kind_s1 <= kind;
            a_s1    <= a;
            b_s1    <= b;
            ac      <= PW'(a) * PW'(tw_re);
            bd      <= PW'(b) * PW'(tw_im);
            ad      <= PW'(a) * PW'(tw_im);
            bc      <= PW'(b) * PW'(tw_re);
        end
    end

    function automatic logic signed [OUT_W-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > MAXV) return OUT_W'(MAXV);
        if (v < MINV) return OUT_W'(MINV);
        return OUT_W'(v);
    endfunction

    logic signed [SW-1:0]    re_sum, im_sum, re_shr, im_shr;
    logic signed [OUT_W-1:0] re_nxt, im_nxt;
    logic                    sat_nxt;

    always_comb begin
        re_sum  = SW'(ac) - SW'(bd) + RND;
        im_sum  = SW'(ad) + SW'(bc) + RND;
        re_shr  = re_sum >>> TW_FRAC;
        im_shr  = im_sum >>> TW_FRAC;
        re_nxt  = OUT_W'(a_s1);
        im_nxt  = OUT_W'(b_s1);
        sat_nxt = 1'b0;
        case (kind_s1)
            TW_MJ: begin
                // widen first so negating the most negative input stays exact
                re_nxt = OUT_W'(b_s1);
                im_nxt = -OUT_W'(a_s1);
            end
            TW_GEN: begin
                re_nxt  = clamp(re_shr);
                im_nxt  = clamp(im_shr);
                sat_nxt = (re_shr > MAXV) || (re_shr < MINV) ||
                          (im_shr > MAXV) || (im_shr < MINV);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_re <= '0;
            o_im <= '0;
            sat  <= 1'b0;
        end else if (en_s2) begin
            o_re <= re_nxt;
            o_im <= im_nxt;
            sat  <= sat_nxt;
        end
    end

endmodule

// File: rtl/twd_mul_stage.sv
// FFT inter-stage twiddle multiplier: beat counter selects a per-block twiddle,
// diff branch goes through LANES multiplier lanes, sum branch is delay-matched.
module twd_mul_stage
    import fft_twd_pkg::*;
#(
    parameter int IN_W      = 11,
    parameter int OUT_W     = 13,
    parameter int TW_FRAC   = TWD_FRAC,
    parameter int LANES     = 16,
    parameter int BLK_LEN   = 4,
    parameter int N_IDX     = TWD_N_IDX,
    parameter int STAGE_SEL = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [LANES-1:0][IN_W-1:0]    i_sum_re,
    input  logic [LANES-1:0][IN_W-1:0]    i_sum_im,
    input  logic [LANES-1:0][IN_W-1:0]    i_diff_re,
    input  logic [LANES-1:0][IN_W-1:0]    i_diff_im,
    output logic                          o_valid,
    output logic                          o_sof,
    output logic [LANES-1:0][OUT_W-1:0]   o_sum_re,
    output logic [LANES-1:0][OUT_W-1:0]   o_sum_im,
    output logic [LANES-1:0][OUT_W-1:0]   o_diff_re,
    output logic [LANES-1:0][OUT_W-1:0]   o_diff_im,
    output logic                          o_sat
);

    localparam int STAGES  = 2;
    localparam int CNT_MAX = N_IDX * BLK_LEN;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (N_IDX > 1) ? $clog2(N_IDX) : 1;

    logic [CW-1:0]              cnt, cnt_eff;
    logic [IW-1:0]              idx;
    twd_t                       tw;
    logic [STAGES:1]            vld_pipe, sof_pipe;
    logic [LANES-1:0][IN_W-1:0] sum_re_s1, sum_im_s1;
    logic [LANES-1:0]           lane_sat;

    // A qualified sof forces this beat onto count 0 regardless of history
    always_comb begin
        cnt_eff = (in_valid && in_sof) ? '0 : cnt;
        idx     = IW'(cnt_eff / CW'(BLK_LEN));
        tw      = TWD_TAB[STAGE_SEL][idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            sof_pipe <= {sof_pipe[STAGES-1:1], in_valid & in_sof};
            if (in_valid)
                cnt <= (cnt_eff == CW'(CNT_MAX - 1)) ? '0 : cnt_eff + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_re_s1 <= '0;
            sum_im_s1 <= '0;
            o_sum_re  <= '0;
            o_sum_im  <= '0;
        end else begin
            if (in_valid) begin
                sum_re_s1 <= i_sum_re;
                sum_im_s1 <= i_sum_im;
            end
            if (vld_pipe[1]) begin
                for (int l = 0; l < LANES; l++) begin
                    o_sum_re[l] <= OUT_W'($signed(sum_re_s1[l]));
                    o_sum_im[l] <= OUT_W'($signed(sum_im_s1[l]));
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cmul_rnd_sat #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .TW_FRAC (TW_FRAC)
        ) u_cmul (
            .clk   (clk),
            .rstn  (rstn),
            .en_s1 (in_valid),
            .en_s2 (vld_pipe[1]),
            .kind  (tw.kind),
            .tw_re (tw.re),
            .tw_im (tw.im),
            .a     (i_diff_re[l]),
            .b     (i_diff_im[l]),
            .o_re  (o_diff_re[l]),
            .o_im  (o_diff_im[l]),
            .sat   (lane_sat[l])
        );
    end

    assign o_valid = vld_pipe[STAGES];
    assign o_sof   = sof_pipe[STAGES];
    assign o_sat   = |lane_sat;

endmodule

// File: tb/tb_twd_mul_stage.sv
// Directed bench for twd_mul_stage: each beat carries its hand-computed result,
// which is checked two cycles later against the outputs.
module tb_twd_mul_stage;

    localparam int IN_W  = 11;
    localparam int OUT_W = 13;
    localparam int LANES = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [LANES-1:0][IN_W-1:0]  i_sum_re, i_sum_im, i_diff_re, i_diff_im;
    logic                        o_valid, o_sof, o_sat;
    logic [LANES-1:0][OUT_W-1:0] o_sum_re, o_sum_im, o_diff_re, o_diff_im;
    logic                        o11_valid, o11_sof, o11_sat;
    logic [LANES-1:0][10:0]      o11_sum_re, o11_sum_im, o11_diff_re, o11_diff_im;

    always #5 clk = ~clk;

    twd_mul_stage #(
        .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .BLK_LEN(4), .N_IDX(4), .STAGE_SEL(1)
    ) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof),
        .i_sum_re(i_sum_re), .i_sum_im(i_sum_im), .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
        .o_valid(o_valid), .o_sof(o_sof), .o_sum_re(o_sum_re), .o_sum_im(o_sum_im),
        .o_diff_re(o_diff_re), .o_diff_im(o_diff_im), .o_sat(o_sat)
    );

    // Narrow-output copy to exercise saturation
    twd_mul_stage #(
        .IN_W(IN_W), .OUT_W(11), .LANES(LANES), .BLK_LEN(4), .N_IDX(4), .STAGE_SEL(1)
    ) u_dut11 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof),
        .i_sum_re(i_sum_re), .i_sum_im(i_sum_im), .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
        .o_valid(o11_valid), .o_sof(o11_sof), .o_sum_re(o11_sum_re), .o_sum_im(o11_sum_im),
        .o_diff_re(o11_diff_re), .o_diff_im(o11_diff_im), .o_sat(o11_sat)
    );

    typedef struct {
        bit    live;
        bit    v;
        bit    sof;
        int    re;
        int    im;
        int    sre;
        int    sim;
        bit    sat;
        bit    c11;
        int    re11;
        int    im11;
        bit    sat11;
        string tag;
    } exp_t;

    exp_t ep0, ep1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   s_re = 7;
    int   s_im = -3;
    bit   g_c11 = 1'b0;
    int   g_re11 = 0;
    int   g_im11 = 0;
    bit   g_sat11 = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ep0.live = 1'b1; ep0.v = 1'b0; ep0.tag = "idle";
        ep1.live = 1'b1; ep1.v = 1'b0; ep1.tag = "idle";
    endtask

    task automatic check_out();
        if (ep1.live) begin
            chk({ep1.tag, "/vld"}, int'(o_valid), int'(ep1.v));
            if (ep1.v) begin
                chk({ep1.tag, "/sof"}, int'(o_sof), int'(ep1.sof));
                chk({ep1.tag, "/re0"}, int'($signed(o_diff_re[0])), ep1.re);
                chk({ep1.tag, "/im0"}, int'($signed(o_diff_im[0])), ep1.im);
                chk({ep1.tag, "/reN"}, int'($signed(o_diff_re[LANES-1])), ep1.re);
                chk({ep1.tag, "/imN"}, int'($signed(o_diff_im[LANES-1])), ep1.im);
                chk({ep1.tag, "/sre0"}, int'($signed(o_sum_re[0])), ep1.sre);
                chk({ep1.tag, "/simN"}, int'($signed(o_sum_im[LANES-1])), ep1.sim - (LANES - 1));
                chk({ep1.tag, "/sat"}, int'(o_sat), int'(ep1.sat));
                if (ep1.c11) begin
                    chk({ep1.tag, "/re11"}, int'($signed(o11_diff_re[0])), ep1.re11);
                    chk({ep1.tag, "/im11"}, int'($signed(o11_diff_im[0])), ep1.im11);
                    chk({ep1.tag, "/sat11"}, int'(o11_sat), int'(ep1.sat11));
                end
            end
        end
    endtask

    task automatic beat(input bit v, input bit sof, input int dre, input int dim,
                        input int ere, input int eim, input bit esat, input string tag);
        @(negedge clk);
        check_out();
        ep1       = ep0;
        ep0.live  = 1'b1;
        ep0.v     = v;
        ep0.sof   = v & sof;
        ep0.re    = ere;
        ep0.im    = eim;
        ep0.sre   = s_re;
        ep0.sim   = s_im;
        ep0.sat   = esat;
        ep0.c11   = g_c11;
        ep0.re11  = g_re11;
        ep0.im11  = g_im11;
        ep0.sat11 = g_sat11;
        ep0.tag   = tag;
        g_c11     = 1'b0;
        in_valid  = v;
        in_sof    = sof;
        for (int l = 0; l < LANES; l++) begin
            i_diff_re[l] = IN_W'(dre);
            i_diff_im[l] = IN_W'(dim);
            i_sum_re[l]  = IN_W'(s_re + l);
            i_sum_im[l]  = IN_W'(s_im - l);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, "idle");
    endtask

    // 100+50j through STAGE_SEL=1 twiddles, selected by the beat count
    task automatic vbeat(input bit sof, input int cnt, input string tag);
        if (cnt < 8)       beat(1'b1, sof, 100, 50, 100, 50, 1'b0, tag);
        else if (cnt < 12) beat(1'b1, sof, 100, 50, 50, -100, 1'b0, tag);
        else               beat(1'b1, sof, 100, 50, 106, -35, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int vb;
        i_sum_re = '0; i_sum_im = '0; i_diff_re = '0; i_diff_im = '0;
        ep0.live = 1'b0;
        ep1.live = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst/vld", int'(o_valid), 0);
        chk("rst/sof", int'(o_sof), 0);
        chk("rst/re0", int'($signed(o_diff_re[0])), 0);
        chk("rst/im0", int'($signed(o_diff_im[0])), 0);
        chk("rst/sre0", int'($signed(o_sum_re[0])), 0);
        chk("rst/sat", int'(o_sat), 0);
        rstn = 1'b1;
        set_idle();

        // Full frame, full rate
        for (int k = 0; k < 16; k++) vbeat(k == 0, k, $sformatf("frm_b%0d", k));
        idle(3);

        // Alternating valid: counter advances on valid beats only
        vb = 0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) begin
                vbeat(1'b0, vb, $sformatf("gap_b%0d", vb));
                vb++;
            end else begin
                beat(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, "gap_idle");
            end
        end

        // sof mid-frame on beat 6 restarts indexing
        for (int k = 0; k < 6; k++) vbeat(k == 0, k, $sformatf("sof_b%0d", k));
        vbeat(1'b1, 0, "sof_restart");
        for (int k = 1; k <= 8; k++) vbeat(1'b0, k, $sformatf("sof_n%0d", k));

        // counts 9..11 then idx 3 with full-scale negative input
        for (int k = 9; k < 12; k++) vbeat(1'b0, k, $sformatf("gen_b%0d", k));
        g_c11 = 1'b1; g_re11 = -1024; g_im11 = 0; g_sat11 = 1'b1;
        beat(1'b1, 1'b0, -1024, -1024, -1448, 0, 1'b0, "gen_min");

        // -j on the most negative real input, with extreme sum values
        for (int k = 0; k < 8; k++) vbeat(k == 0, k, $sformatf("mj_b%0d", k));
        s_re = -1024; s_im = 1023;
        beat(1'b1, 1'b0, -1024, 0, 0, 1024, 1'b0, "mj_min");
        s_re = 7; s_im = -3;

        // Reset mid-frame with beats in flight
        for (int k = 9; k < 12; k++) vbeat(1'b0, k, $sformatf("pre_rst%0d", k));
        #2;
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst/vld", int'(o_valid), 0);
        chk("mid_rst/re0", int'($signed(o_diff_re[0])), 0);
        chk("mid_rst/im0", int'($signed(o_diff_im[0])), 0);
        chk("mid_rst/sre0", int'($signed(o_sum_re[0])), 0);
        chk("mid_rst/sat11", int'(o11_sat), 0);
        set_idle();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k <= 8; k++) vbeat(1'b0, k, $sformatf("post_rst%0d", k));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
